// File: rtl/pipe_stage_reg.sv
// pipe_stage_reg: pipeline stage register with valid/ready handshake, flush,
// optional skid slot and a saturating stall counter.
//
// Ports:
//   CLK        in   1      clock, rising edge
//   RESET      in   1      asynchronous active-high reset
//   D          in   WIDTH  upstream payload
//   IN_VALID   in   1      upstream word valid
//   IN_READY   out  1      stage accepts a word this cycle
//   Q          out  WIDTH  downstream payload, BUBBLE when OUT_VALID=0
//   OUT_VALID  out  1      Q holds a valid word
//   OUT_READY  in   1      downstream accepts Q this cycle
//   FLUSH      in   1      synchronous squash of all held words
//   CNT_CLR    in   1      synchronous clear of STALL_CNT
//   STALL_CNT  out  CNT_W  saturating count of OUT_VALID & !OUT_READY cycles
module pipe_stage_reg #(
  parameter int unsigned      WIDTH   = 64,
  parameter logic [WIDTH-1:0] BUBBLE  = '0,
  parameter bit               SKID_EN = 1'b1,
  parameter int unsigned      CNT_W   = 16
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] D,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] Q,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             FLUSH,
  input  logic             CNT_CLR,
  output logic [CNT_W-1:0] STALL_CNT
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_BUSY  = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic [WIDTH-1:0] skid_q, skid_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             in_xfer;
  logic             out_xfer;
  logic             stall;

  // Handshake decode; with the skid slot IN_READY depends on state only.
  assign OUT_VALID = (state_q != ST_EMPTY);
  assign IN_READY  = SKID_EN ? (state_q != ST_FULL)
                             : ((state_q == ST_EMPTY) || OUT_READY);
  assign in_xfer   = IN_VALID && IN_READY;
  assign out_xfer  = OUT_VALID && OUT_READY;
  assign stall     = OUT_VALID && !OUT_READY;

  assign Q         = q_q;
  assign STALL_CNT = cnt_q;

  // State, payload and counter registers.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state_q <= ST_EMPTY;
      q_q     <= BUBBLE;
      skid_q  <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      skid_q  <= skid_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next-state and payload steering; every path into EMPTY reloads BUBBLE.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    skid_d  = skid_q;

    if (FLUSH) begin
      state_d = ST_EMPTY;
      q_d     = BUBBLE;
      skid_d  = '0;
    end else begin
      case (state_q)
        ST_EMPTY: begin
          if (in_xfer) begin
            state_d = ST_BUSY;
            q_d     = D;
          end
        end
        ST_BUSY: begin
          if (in_xfer && out_xfer) begin
            q_d = D;
          end else if (out_xfer) begin
            state_d = ST_EMPTY;
            q_d     = BUBBLE;
          end else if (in_xfer && SKID_EN) begin
            state_d = ST_FULL;
            skid_d  = D;
          end
        end
        ST_FULL: begin
          if (out_xfer) begin
            state_d = ST_BUSY;
            q_d     = skid_q;
          end
        end
        default: begin
          state_d = ST_EMPTY;
          q_d     = BUBBLE;
        end
      endcase
    end
  end

  // Stall counter: clear wins, otherwise saturating increment.
  always_comb begin
    cnt_d = cnt_q;
    if (CNT_CLR) begin
      cnt_d = '0;
    end else if (stall && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// tb_pipe_stage_reg: self-checking bench for pipe_stage_reg.
// u_skid (skid slot, 16-bit counter) and u_cnt (skid slot, 4-bit counter)
// share one stimulus set; u_pass (no skid slot) has its own.
// Words accepted are queued per stage and compared when consumed downstream.
module tb_pipe_stage_reg;

  localparam logic [63:0] BUB_S = 64'hDEAD_BEEF_0BAD_F00D;
  localparam logic [63:0] BUB_P = 64'h5A5A_5A5A_A5A5_A5A5;

  logic        clk;
  logic        rst;

  logic [63:0] s_d;
  logic        s_iv, s_or, s_fl, s_cc;
  logic        s_ir, s_ov, c_ir, c_ov;
  logic [63:0] s_q, c_q;
  logic [15:0] s_cnt;
  logic [3:0]  c_cnt;

  logic [63:0] p_d;
  logic        p_iv, p_or, p_fl, p_cc;
  logic        p_ir, p_ov;
  logic [63:0] p_q;
  logic [15:0] p_cnt;

  int checks = 0;
  int errors = 0;

  logic [63:0] sq[$];
  logic [63:0] pq[$];

  pipe_stage_reg #(.WIDTH(64), .BUBBLE(BUB_S), .SKID_EN(1'b1), .CNT_W(16)) u_skid (
    .CLK(clk), .RESET(rst), .D(s_d), .IN_VALID(s_iv), .IN_READY(s_ir),
    .Q(s_q), .OUT_VALID(s_ov), .OUT_READY(s_or), .FLUSH(s_fl),
    .CNT_CLR(s_cc), .STALL_CNT(s_cnt));

  pipe_stage_reg #(.WIDTH(64), .BUBBLE(BUB_S), .SKID_EN(1'b1), .CNT_W(4)) u_cnt (
    .CLK(clk), .RESET(rst), .D(s_d), .IN_VALID(s_iv), .IN_READY(c_ir),
    .Q(c_q), .OUT_VALID(c_ov), .OUT_READY(s_or), .FLUSH(s_fl),
    .CNT_CLR(s_cc), .STALL_CNT(c_cnt));

  pipe_stage_reg #(.WIDTH(64), .BUBBLE(BUB_P), .SKID_EN(1'b0), .CNT_W(16)) u_pass (
    .CLK(clk), .RESET(rst), .D(p_d), .IN_VALID(p_iv), .IN_READY(p_ir),
    .Q(p_q), .OUT_VALID(p_ov), .OUT_READY(p_or), .FLUSH(p_fl),
    .CNT_CLR(p_cc), .STALL_CNT(p_cnt));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One clock: scoreboard bookkeeping on pre-edge values, then advance to the
  // next falling edge where stimulus is changed.
  task automatic cycle();
    logic [63:0] e;
    #1;
    if (s_ov && s_or) begin
      checks++;
      if (sq.size() == 0) begin
        errors++;
        $display("FAIL sb_skid: output %h with nothing expected", s_q);
      end else begin
        e = sq.pop_front();
        if (s_q !== e || c_q !== e) begin
          errors++;
          $display("FAIL sb_skid: got %h / %h expected %h", s_q, c_q, e);
        end
      end
    end
    if (s_fl) sq.delete();
    else if (s_iv && s_ir) sq.push_back(s_d);

    if (p_ov && p_or) begin
      checks++;
      if (pq.size() == 0) begin
        errors++;
        $display("FAIL sb_pass: output %h with nothing expected", p_q);
      end else begin
        e = pq.pop_front();
        if (p_q !== e) begin
          errors++;
          $display("FAIL sb_pass: got %h expected %h", p_q, e);
        end
      end
    end
    if (p_fl) pq.delete();
    else if (p_iv && p_ir) pq.push_back(p_d);

    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic test_reset();
    // Put both stages in BUSY with stalls accruing, then reset mid-cycle.
    s_iv = 1'b1; s_d = 64'h11; s_or = 1'b0;
    p_iv = 1'b1; p_d = 64'h22; p_or = 1'b0;
    cycle();
    s_iv = 1'b0; p_iv = 1'b0;
    cycle();
    #2;
    rst = 1'b1;
    s_d = '1; s_iv = 1'b1;
    p_d = '1; p_iv = 1'b1;
    #1;
    checks++;
    if (s_q !== BUB_S || s_ov !== 1'b0 || s_ir !== 1'b1 || s_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_skid: q=%h ov=%b ir=%b cnt=%0d expected q=%h ov=0 ir=1 cnt=0",
               s_q, s_ov, s_ir, s_cnt, BUB_S);
    end
    checks++;
    if (c_cnt !== 4'd0 || c_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_cnt: cnt=%0d ov=%b expected cnt=0 ov=0", c_cnt, c_ov);
    end
    checks++;
    if (p_q !== BUB_P || p_ov !== 1'b0 || p_ir !== 1'b1 || p_cnt !== 16'd0) begin
      errors++;
      $display("FAIL reset_pass: q=%h ov=%b ir=%b cnt=%0d expected q=%h ov=0 ir=1 cnt=0",
               p_q, p_ov, p_ir, p_cnt, BUB_P);
    end
    sq.delete();
    pq.delete();
    @(negedge clk);
    checks++;
    if (s_q !== BUB_S || s_ov !== 1'b0) begin
      errors++;
      $display("FAIL reset_hold: q=%h ov=%b expected q=%h ov=0", s_q, s_ov, BUB_S);
    end
    rst = 1'b0; s_iv = 1'b0; p_iv = 1'b0;
    s_d = '0; p_d = '0;
  endtask

  task automatic test_streaming();
    logic [63:0] v;
    s_or = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      v = 64'(i);
      s_d = v; s_iv = 1'b1;
      cycle();
      checks++;
      if (s_q !== v || s_ov !== 1'b1) begin
        errors++;
        $display("FAIL stream_word%0d: q=%h ov=%b expected q=%h ov=1", i, s_q, s_ov, v);
      end
    end
    s_iv = 1'b0;
    cycle();
    checks++;
    if (s_q !== BUB_S || s_ov !== 1'b0) begin
      errors++;
      $display("FAIL stream_bubble: q=%h ov=%b expected q=%h ov=0", s_q, s_ov, BUB_S);
    end
  endtask

  task automatic test_backpressure();
    logic [63:0] a;
    logic [63:0] b;
    a = 64'hAAAA_0000_0000_000A;
    b = 64'hBBBB_0000_0000_000B;
    s_or = 1'b0;
    s_d = a; s_iv = 1'b1;
    cycle();
    s_d = b;
    cycle();
    s_iv = 1'b0;
    #1;
    checks++;
    if (s_ir !== 1'b0 || s_q !== a) begin
      errors++;
      $display("FAIL bp_full: ir=%b q=%h expected ir=0 q=%h", s_ir, s_q, a);
    end
    cycle();
    cycle();
    checks++;
    if (s_cnt !== 16'd3 || s_q !== a) begin
      errors++;
      $display("FAIL bp_stall: cnt=%0d q=%h expected cnt=3 q=%h", s_cnt, s_q, a);
    end
    s_or = 1'b1;
    cycle();
    checks++;
    if (s_q !== b || s_ov !== 1'b1 || s_ir !== 1'b1) begin
      errors++;
      $display("FAIL bp_drain_b: q=%h ov=%b ir=%b expected q=%h ov=1 ir=1", s_q, s_ov, s_ir, b);
    end
    cycle();
    checks++;
    if (s_ov !== 1'b0 || s_q !== BUB_S || s_cnt !== 16'd3) begin
      errors++;
      $display("FAIL bp_empty: ov=%b q=%h cnt=%0d expected ov=0 q=%h cnt=3", s_ov, s_q, s_cnt, BUB_S);
    end
  endtask

  task automatic test_flush();
    logic [63:0] c;
    c = 64'hCCCC_CCCC_CCCC_CCCC;
    // Flush from BUSY with a word accepted in the same cycle: it is dropped.
    s_or = 1'b0;
    s_d = 64'h0A; s_iv = 1'b1;
    cycle();
    s_d = c; s_fl = 1'b1;
    cycle();
    s_fl = 1'b0; s_iv = 1'b0;
    #1;
    checks++;
    if (s_ov !== 1'b0 || s_q !== BUB_S || s_ir !== 1'b1) begin
      errors++;
      $display("FAIL flush_busy: ov=%b q=%h ir=%b expected ov=0 q=%h ir=1", s_ov, s_q, s_ir, BUB_S);
    end
    // Flush from FULL with C offered.
    s_d = 64'h0A; s_iv = 1'b1;
    cycle();
    s_d = 64'h0B;
    cycle();
    s_d = c; s_fl = 1'b1;
    cycle();
    s_fl = 1'b0; s_iv = 1'b0;
    #1;
    checks++;
    if (s_ov !== 1'b0 || s_q !== BUB_S || s_ir !== 1'b1) begin
      errors++;
      $display("FAIL flush_full: ov=%b q=%h ir=%b expected ov=0 q=%h ir=1", s_ov, s_q, s_ir, BUB_S);
    end
    s_or = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cycle();
      checks++;
      if (s_ov !== 1'b0 || s_q !== BUB_S) begin
        errors++;
        $display("FAIL flush_no_c: ov=%b q=%h expected ov=0 q=%h", s_ov, s_q, BUB_S);
      end
    end
  endtask

  task automatic test_passthrough();
    logic [63:0] x1;
    logic [63:0] x2;
    x1 = 64'h1111_2222_3333_4444;
    x2 = 64'h5555_6666_7777_8888;
    p_or = 1'b1; p_d = x1; p_iv = 1'b1;
    cycle();
    p_or = 1'b0; p_d = x2;
    #1;
    checks++;
    if (p_ir !== 1'b0 || p_q !== x1) begin
      errors++;
      $display("FAIL pass_block: ir=%b q=%h expected ir=0 q=%h", p_ir, p_q, x1);
    end
    cycle();
    checks++;
    if (p_q !== x1 || p_ov !== 1'b1) begin
      errors++;
      $display("FAIL pass_hold: q=%h ov=%b expected q=%h ov=1", p_q, p_ov, x1);
    end
    p_or = 1'b1;
    #1;
    checks++;
    if (p_ir !== 1'b1) begin
      errors++;
      $display("FAIL pass_comb_ready: ir=%b expected 1", p_ir);
    end
    cycle();
    checks++;
    if (p_q !== x2 || p_ov !== 1'b1) begin
      errors++;
      $display("FAIL pass_replace: q=%h ov=%b expected q=%h ov=1", p_q, p_ov, x2);
    end
    p_iv = 1'b0;
    cycle();
    checks++;
    if (p_q !== BUB_P || p_ov !== 1'b0) begin
      errors++;
      $display("FAIL pass_bubble: q=%h ov=%b expected q=%h ov=0", p_q, p_ov, BUB_P);
    end
  endtask

  task automatic test_counter();
    s_cc = 1'b1; s_or = 1'b1; s_iv = 1'b0;
    cycle();
    s_cc = 1'b0; s_or = 1'b0;
    s_d = 64'h77; s_iv = 1'b1;
    cycle();
    s_iv = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    checks++;
    if (c_cnt !== 4'd15 || s_cnt !== 16'd20) begin
      errors++;
      $display("FAIL cnt_saturate: cnt4=%0d cnt16=%0d expected 15 and 20", c_cnt, s_cnt);
    end
    s_cc = 1'b1;
    cycle();
    checks++;
    if (c_cnt !== 4'd0 || s_cnt !== 16'd0) begin
      errors++;
      $display("FAIL cnt_clear: cnt4=%0d cnt16=%0d expected 0 and 0", c_cnt, s_cnt);
    end
    s_cc = 1'b0;
    cycle();
    checks++;
    if (c_cnt !== 4'd1) begin
      errors++;
      $display("FAIL cnt_restart: cnt4=%0d expected 1", c_cnt);
    end
    s_or = 1'b1;
    cycle();
    cycle();
  endtask

  initial begin
    rst = 1'b1;
    s_d = '0; s_iv = 1'b0; s_or = 1'b0; s_fl = 1'b0; s_cc = 1'b0;
    p_d = '0; p_iv = 1'b0; p_or = 1'b0; p_fl = 1'b0; p_cc = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;

    test_reset();
    test_streaming();
    test_backpressure();
    test_flush();
    test_passthrough();
    test_counter();

    checks++;
    if (sq.size() != 0 || pq.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: %0d / %0d words never seen, expected 0", sq.size(), pq.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
